// File: rtl/mux_arb2x8_pkg.sv
// Typed views of the shared arbiter constants, imported by the arbiter top.
package mux_arb2x8_pkg;

`include "mux_arb_defs.vh"

  localparam logic SRC_A     = `MUX_ARB_SRC_A;
  localparam logic SRC_B     = `MUX_ARB_SRC_B;
  localparam int   CNT_W_DEF = `MUX_ARB_CNT_W;

  typedef enum logic {
    EMPTY = `MUX_ARB_EMPTY,
    FULL  = `MUX_ARB_FULL
  } out_state_t;

endpackage

// File: rtl/mux16to8.sv
// Gate-level 2:1 mux over two WIDTH-bit words (8 bits by default): y = sel ? b : a.
module mux16to8 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  wire             sel_n;
  wire [WIDTH-1:0] and_a;
  wire [WIDTH-1:0] and_b;

  not u_inv (sel_n, sel);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and u_and_a (and_a[i], a[i], sel_n);
    and u_and_b (and_b[i], b[i], sel);
    or  u_or    (y[i], and_a[i], and_b[i]);
  end

endmodule

// File: rtl/mux_arb_defs.vh
// Shared constants for the mux_arb2x8 arbiter: source indices, output
// register state encoding and the default beat-counter width.
`ifndef MUX_ARB_DEFS_VH
`define MUX_ARB_DEFS_VH

`define MUX_ARB_SRC_A 1'b0
`define MUX_ARB_SRC_B 1'b1
`define MUX_ARB_EMPTY 1'b0
`define MUX_ARB_FULL  1'b1
`define MUX_ARB_CNT_W 8

`endif

// File: rtl/mux_arb2x8.sv
// Two-source valid/ready arbiter feeding a one-entry output register.
// Define MUX_ARB_RR_EN for round-robin contention; default is fixed priority (A wins).
module mux_arb2x8
  import mux_arb2x8_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  out_state_t       state;
  logic [WIDTH-1:0] data_q;
  logic             src_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;
  logic [WIDTH-1:0] mux_y;
  logic             load_ok;
  logic             contend_grant;
  logic             grant;
  logic             accept;

`ifdef MUX_ARB_RR_EN
  logic last;
  assign contend_grant = ~last;
`else
  assign contend_grant = SRC_A;
`endif

  // Readies are held low during reset so no beat slips in on the reset edge.
  always_comb begin
    load_ok = (state == EMPTY) || out_ready;
    if (a_valid && b_valid) begin
      grant = contend_grant;
    end else if (b_valid) begin
      grant = SRC_B;
    end else begin
      grant = SRC_A;
    end
    accept  = load_ok && (a_valid || b_valid) && !rst;
    a_ready = accept && (grant == SRC_A);
    b_ready = accept && (grant == SRC_B);
  end

  mux16to8 #(.WIDTH(WIDTH)) u_mux (
    .a   (a_data),
    .b   (b_data),
    .sel (grant),
    .y   (mux_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      data_q  <= '0;
      src_q   <= SRC_A;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (accept) begin
      state  <= FULL;
      data_q <= mux_y;
      src_q  <= grant;
      if (grant == SRC_A) begin
        cnt_a_q <= cnt_a_q + CNT_W'(1);
      end else begin
        cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
    end else if ((state == FULL) && out_ready) begin
      state <= EMPTY;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Pointer starts at B so that A wins the first contention after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= SRC_B;
    end else if (accept) begin
      last <= grant;
    end
  end
`endif

  assign out_valid = (state == FULL);
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_mux_arb2x8.sv
// Directed self-checking bench for mux_arb2x8; contention expectations follow MUX_ARB_RR_EN.
module tb_mux_arb2x8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid, out_ready;
  logic       a_ready, b_ready, out_valid, out_src;
  logic [7:0] out_data, cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       av;
    logic [7:0] ad;
    logic       bv;
    logic [7:0] bd;
    logic       ordy;
    logic       ear;
    logic       ebr;
    logic       eov;
    logic [7:0] eod;
    logic       esrc;
    logic [7:0] eca;
    logic [7:0] ecb;
  } vec_t;

  vec_t vecs [12];

  mux_arb2x8 dut (
    .clk       (clk),
    .rst       (rst),
    .a_data    (a_data),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .b_data    (b_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [7:0] ad, input logic bv,
                               input logic [7:0] bd, input logic ordy);
    a_valid   = av;
    a_data    = ad;
    b_valid   = bv;
    b_data    = bd;
    out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       g;
    logic       last_m;
    int         ea, eb, n;

    //             av  ad     bv  bd     rdy  ar  br  ov  od     src ca  cb
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1, 8'd0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'd2, 8'd0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 8'd3, 8'd0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 8'd3, 8'd0};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'h5C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5C, 1'b1, 8'd3, 8'd1};
    vecs[5]  = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 8'd3, 8'd1};
    vecs[6]  = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 8'd3, 8'd1};
    vecs[7]  = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 8'd3, 8'd1};
    vecs[8]  = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5C, 1'b1, 8'd3, 8'd1};
    vecs[9]  = '{1'b1, 8'h66, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 1'b0, 8'd4, 8'd1};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66, 1'b0, 8'd4, 8'd1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h66, 1'b0, 8'd4, 8'd1};

    // Two reset cycles with A presenting a beat: nothing may be accepted.
    rst = 1'b1;
    applyStimulus(1'b1, 8'h99, 1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 2; c++) begin
      checkOutput("rst_a_ready", a_ready, 0);
      checkOutput("rst_b_ready", b_ready, 0);
      tick();
    end
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_src", out_src, 0);
    checkOutput("rst_cnt_a", cnt_a, 0);
    checkOutput("rst_cnt_b", cnt_b, 0);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd, vecs[i].ordy);
      checkOutput($sformatf("v%0d_a_ready", i), a_ready, vecs[i].ear);
      checkOutput($sformatf("v%0d_b_ready", i), b_ready, vecs[i].ebr);
      tick();
      checkOutput($sformatf("v%0d_out_valid", i), out_valid, vecs[i].eov);
      checkOutput($sformatf("v%0d_out_data", i), out_data, vecs[i].eod);
      checkOutput($sformatf("v%0d_out_src", i), out_src, vecs[i].esrc);
      checkOutput($sformatf("v%0d_cnt_a", i), cnt_a, vecs[i].eca);
      checkOutput($sformatf("v%0d_cnt_b", i), cnt_b, vecs[i].ecb);
    end

    // Contention: last accepted beat came from A.
    ea = 4;
    eb = 1;
    last_m = 1'b0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
`ifdef MUX_ARB_RR_EN
      g = ~last_m;
`else
      g = 1'b0;
`endif
      checkOutput($sformatf("cont%0d_a_ready", c), a_ready, !g);
      checkOutput($sformatf("cont%0d_b_ready", c), b_ready, g);
      tick();
      checkOutput($sformatf("cont%0d_out_data", c), out_data, g ? 8'hBB : 8'hAA);
      checkOutput($sformatf("cont%0d_out_src", c), out_src, g);
      if (g) eb++;
      else   ea++;
      last_m = g;
      checkOutput($sformatf("cont%0d_cnt_a", c), cnt_a, ea);
      checkOutput($sformatf("cont%0d_cnt_b", c), cnt_b, eb);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();
    checkOutput("drain_out_valid", out_valid, 0);

    // Counter wrap: bring cnt_b to zero, then a further 256 B accepts.
    n = (256 - eb) % 256;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
      tick();
    end
    checkOutput("wrap1_cnt_b", cnt_b, 0);
    checkOutput("wrap1_cnt_a", cnt_a, ea % 256);
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
      tick();
    end
    checkOutput("wrap2_cnt_b", cnt_b, 0);
    checkOutput("wrap2_cnt_a", cnt_a, ea % 256);
    checkOutput("wrap2_out_data", out_data, 8'hFF);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    tick();

    // Reset while a beat from A is held and undelivered.
    applyStimulus(1'b1, 8'h7E, 1'b0, 8'h00, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    checkOutput("mid_out_valid", out_valid, 1);
    checkOutput("mid_out_data", out_data, 8'h7E);
    rst = 1'b1;
    applyStimulus(1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
    checkOutput("mid_rst_a_ready", a_ready, 0);
    checkOutput("mid_rst_b_ready", b_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("post_rst_out_valid", out_valid, 0);
    checkOutput("post_rst_out_data", out_data, 0);
    checkOutput("post_rst_cnt_a", cnt_a, 0);
    checkOutput("post_rst_cnt_b", cnt_b, 0);
    checkOutput("post_rst_a_ready", a_ready, 1);
    checkOutput("post_rst_b_ready", b_ready, 0);
    tick();
    checkOutput("post_rst_grant_data", out_data, 8'hAA);
    checkOutput("post_rst_grant_src", out_src, 0);
    checkOutput("post_rst_grant_cnt_a", cnt_a, 1);
    checkOutput("post_rst_grant_cnt_b", cnt_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
